// File: rtl/demux32_1to2_reg.sv
// Registered 1-to-2 word router: one source stream steered to port A or B
// by a per-beat select, with a one-entry valid/ready slot on each output.
//
// Ports:
//   Clk, Rst             clock, synchronous active-low reset
//   inData/inValid/sel   source word, beat present, destination (0=A, 1=B)
//   inReady              combinational accept, depends on the selected port only
//   outA/outAValid/outAReady  port A registered word and handshake
//   outB/outBValid/outBReady  port B registered word and handshake
//   cntA/cntB            delivered-beat counters (macro DEMUX_BEAT_CNT_EN),
//                        tied to zero when the macro is undefined
module demux32_1to2_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] inData,
  input  logic             inValid,
  input  logic             sel,
  output logic             inReady,
  output logic [WIDTH-1:0] outA,
  output logic             outAValid,
  input  logic             outAReady,
  output logic [WIDTH-1:0] outB,
  output logic             outBValid,
  input  logic             outBReady,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB
);

  logic             a_vld_q, a_vld_d;
  logic             b_vld_q, b_vld_d;
  logic [WIDTH-1:0] a_dat_q, a_dat_d;
  logic [WIDTH-1:0] b_dat_q, b_dat_d;
  logic             a_free;
  logic             b_free;
  logic             acc_a;
  logic             acc_b;

  // A slot can take a new word if it is empty or drains this edge.
  always_comb begin
    a_free  = !a_vld_q || outAReady;
    b_free  = !b_vld_q || outBReady;
    inReady = Rst && (sel ? b_free : a_free);
    acc_a   = inValid && inReady && !sel;
    acc_b   = inValid && inReady && sel;
  end

  always_comb begin
    a_vld_d = a_vld_q;
    a_dat_d = a_dat_q;
    if (acc_a) begin
      a_vld_d = 1'b1;
      a_dat_d = inData;
    end else if (outAReady) begin
      a_vld_d = 1'b0;
    end
  end

  always_comb begin
    b_vld_d = b_vld_q;
    b_dat_d = b_dat_q;
    if (acc_b) begin
      b_vld_d = 1'b1;
      b_dat_d = inData;
    end else if (outBReady) begin
      b_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_dat_q <= '0;
      b_dat_q <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      a_dat_q <= a_dat_d;
      b_dat_q <= b_dat_d;
    end
  end

  assign outA      = a_dat_q;
  assign outAValid = a_vld_q;
  assign outB      = b_dat_q;
  assign outBValid = b_vld_q;

`ifdef DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Natural wrap modulo 2^CNT_W.
  always_comb begin
    cnt_a_d = cnt_a_q + CNT_W'(a_vld_q && outAReady);
    cnt_b_d = cnt_b_q + CNT_W'(b_vld_q && outBReady);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cntA = cnt_a_q;
  assign cntB = cnt_b_q;
`else
  assign cntA = '0;
  assign cntB = '0;
`endif

endmodule

// File: tb/tb_demux32_1to2_reg.sv
// Self-checking bench for demux32_1to2_reg: directed vector table plus
// randomized traffic against a queue-based reference model.
module tb_demux32_1to2_reg;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] inData = '0;
  logic        inValid = 1'b0;
  logic        sel = 1'b0;
  logic        inReady;
  logic [31:0] outA;
  logic        outAValid;
  logic        outAReady = 1'b0;
  logic [31:0] outB;
  logic        outBValid;
  logic        outBReady = 1'b0;
  logic [15:0] cntA;
  logic [15:0] cntB;

  always #5 Clk = ~Clk;

  demux32_1to2_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .inData(inData), .inValid(inValid), .sel(sel),
    .inReady(inReady),
    .outA(outA), .outAValid(outAValid), .outAReady(outAReady),
    .outB(outB), .outBValid(outBValid), .outBReady(outBReady),
    .cntA(cntA), .cntB(cntB)
  );

  typedef struct packed {
    logic        rst;
    logic        v;
    logic        s;
    logic [31:0] d;
    logic        ra;
    logic        rb;
    logic        e_rdy;
    logic        e_av;
    logic [31:0] e_a;
    logic        e_bv;
    logic [31:0] e_b;
    logic        chk_z;
  } vec_t;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int unsigned ca = 0;
  int unsigned cb = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(
    input logic rst, input logic v, input logic s, input logic [31:0] d,
    input logic ra, input logic rb, input logic e_rdy,
    input logic e_av, input logic [31:0] e_a,
    input logic e_bv, input logic [31:0] e_b, input logic chk_z);
    vec_t t;
    t.rst = rst; t.v = v; t.s = s; t.d = d; t.ra = ra; t.rb = rb;
    t.e_rdy = e_rdy; t.e_av = e_av; t.e_a = e_a;
    t.e_bv = e_bv; t.e_b = e_b; t.chk_z = chk_z;
    return t;
  endfunction

  task automatic drive(input logic rst, input logic v, input logic s,
                       input logic [31:0] d, input logic ra, input logic rb);
    Rst = rst; inValid = v; sel = s; inData = d;
    outAReady = ra; outBReady = rb;
  endtask

  // Model view: each port is a queue of at most one pending word.
  task automatic model_check();
    logic rdy;
    rdy = Rst && (sel ? (qb.size() == 0 || outBReady)
                      : (qa.size() == 0 || outAReady));
    chk("m_inReady", {31'd0, inReady}, {31'd0, rdy});
    chk("m_outAValid", {31'd0, outAValid}, {31'd0, qa.size() != 0});
    chk("m_outBValid", {31'd0, outBValid}, {31'd0, qb.size() != 0});
    if (qa.size() != 0) chk("m_outA", outA, qa[0]);
    if (qb.size() != 0) chk("m_outB", outB, qb[0]);
`ifdef DEMUX_BEAT_CNT_EN
    chk("m_cntA", {16'd0, cntA}, ca);
    chk("m_cntB", {16'd0, cntB}, cb);
`else
    chk("m_cntA", {16'd0, cntA}, 32'd0);
    chk("m_cntB", {16'd0, cntB}, 32'd0);
`endif
  endtask

  task automatic model_step();
    logic rdy;
    if (!Rst) begin
      qa.delete();
      qb.delete();
      ca = 0;
      cb = 0;
    end else begin
      rdy = sel ? (qb.size() == 0 || outBReady)
                : (qa.size() == 0 || outAReady);
      if (outAReady && qa.size() != 0) begin
        void'(qa.pop_front());
        ca = (ca + 1) & 32'hFFFF;
      end
      if (outBReady && qb.size() != 0) begin
        void'(qb.pop_front());
        cb = (cb + 1) & 32'hFFFF;
      end
      if (inValid && rdy) begin
        if (sel) qb.push_back(inData);
        else qa.push_back(inData);
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic s,
                       input logic [31:0] d, input logic ra, input logic rb);
    @(negedge Clk);
    drive(rst, v, s, d, ra, rb);
    #1;
    model_check();
    @(posedge Clk);
    model_step();
  endtask

  vec_t vt[19];

  initial begin
    vt[0]  = mk(0,1,0,32'h11,      1,1, 0, 0,0,           0,0,           1);
    vt[1]  = mk(0,1,1,32'h22,      1,1, 0, 0,0,           0,0,           1);
    vt[2]  = mk(0,1,0,32'h33,      1,1, 0, 0,0,           0,0,           1);
    vt[3]  = mk(1,1,0,32'hDEADBEEF,1,1, 1, 0,0,           0,0,           1);
    vt[4]  = mk(1,1,1,32'h12345678,1,1, 1, 1,32'hDEADBEEF,0,0,           0);
    vt[5]  = mk(1,0,0,32'h0,       1,1, 1, 0,0,           1,32'h12345678,0);
    vt[6]  = mk(1,1,0,32'hAAAA0001,0,1, 1, 0,0,           0,0,           0);
    vt[7]  = mk(1,1,0,32'hAAAA0002,0,1, 0, 1,32'hAAAA0001,0,0,           0);
    vt[8]  = mk(1,1,1,32'h0000BBBB,0,1, 1, 1,32'hAAAA0001,0,0,           0);
    vt[9]  = mk(1,0,0,32'h0,       0,1, 0, 1,32'hAAAA0001,1,32'h0000BBBB,0);
    vt[10] = mk(1,1,0,32'h2,       1,1, 1, 1,32'hAAAA0001,0,0,           0);
    vt[11] = mk(1,0,0,32'h0,       1,1, 1, 1,32'h2,       0,0,           0);
    vt[12] = mk(1,0,0,32'h0,       1,1, 1, 0,0,           0,0,           0);
    vt[13] = mk(1,1,0,32'hCAFE0001,0,0, 1, 0,0,           0,0,           0);
    vt[14] = mk(1,1,1,32'hCAFE0002,0,0, 1, 1,32'hCAFE0001,0,0,           0);
    vt[15] = mk(1,1,0,32'hCAFE0003,0,0, 0, 1,32'hCAFE0001,1,32'hCAFE0002,0);
    vt[16] = mk(0,1,0,32'hCAFE0004,0,0, 0, 1,32'hCAFE0001,1,32'hCAFE0002,0);
    vt[17] = mk(1,0,0,32'h0,       1,1, 1, 0,0,           0,0,           1);
    vt[18] = mk(1,0,0,32'h0,       1,1, 1, 0,0,           0,0,           1);

    drive(0, 1, 0, 32'h0, 0, 0);
    @(posedge Clk);
    model_step();

    for (int i = 0; i < 19; i++) begin
      @(negedge Clk);
      drive(vt[i].rst, vt[i].v, vt[i].s, vt[i].d, vt[i].ra, vt[i].rb);
      #1;
      model_check();
      chk($sformatf("t%0d_inReady", i), {31'd0, inReady},
          {31'd0, vt[i].e_rdy});
      chk($sformatf("t%0d_outAValid", i), {31'd0, outAValid},
          {31'd0, vt[i].e_av});
      chk($sformatf("t%0d_outBValid", i), {31'd0, outBValid},
          {31'd0, vt[i].e_bv});
      if (vt[i].e_av || vt[i].chk_z)
        chk($sformatf("t%0d_outA", i), outA, vt[i].e_a);
      if (vt[i].e_bv || vt[i].chk_z)
        chk($sformatf("t%0d_outB", i), outB, vt[i].e_b);
      @(posedge Clk);
      model_step();
    end

    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(63) != 0), ($urandom_range(3) != 0),
            1'($urandom_range(1)), $urandom,
            ($urandom_range(3) != 0), ($urandom_range(2) != 0));
    end

`ifdef DEMUX_BEAT_CNT_EN
    cycle(0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 65537; i++)
      cycle(1, 1, 0, 32'(i), 1, 0);
    @(negedge Clk);
    drive(1, 0, 0, 32'h0, 0, 0);
    #1;
    chk("wrap_cntA", {16'd0, cntA}, 32'd0);
    chk("wrap_cntB", {16'd0, cntB}, 32'd0);
    @(posedge Clk);
    model_step();
`endif

    cycle(1, 0, 0, 32'h0, 1, 1);
    cycle(1, 0, 0, 32'h0, 1, 1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/demux32_1to2_reg.md
Name: demux32_1to2_reg

Overview:
- Registered 1-to-2 word router: one 32-bit source stream is steered to one of two destination streams by a per-beat select.
- Mirror of the datapath's 2:1 word selector; used where a single producer (e.g. writeback/forwarding data) must feed one of two consumers that can stall.
- Each output has a one-entry holding register with valid/ready handshake. Latency is 1 cycle, and full throughput is sustained when consumers are ready.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 16, width of per-port beat counters (used only with the optional feature).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  reset; synchronous, active-low (0 = reset, sampled on rising Clk).
- inData  input  WIDTH  source word.
- inValid  input  1  source beat present.
- sel  input  1  destination of the current beat: 0 = port A, 1 = port B. Sampled with inData.
- inReady  output  1  beat accepted this cycle when inValid & inReady.
- outA  output  WIDTH  port A word (registered).
- outAValid  output  1  port A word valid.
- outAReady  input  1  port A consumer accepts.
- outB  output  WIDTH  port B word (registered).
- outBValid  output  1  port B word valid.
- outBReady  input  1  port B consumer accepts.
- cntA  output  CNT_W  beats delivered on A (optional feature only).
- cntB  output  CNT_W  beats delivered on B (optional feature only).

Behaviour:
- Reset (Rst=0 at a rising edge): outAValid=0, outBValid=0, outA=0, outB=0, cntA=0, cntB=0.
  - inReady is forced to 0 while Rst=0.
  - Reset mid-transfer discards held words. No beat is delivered in the cycle after reset.
- Per-port slot state: EMPTY (valid=0) or FULL (valid=1). Port A and port B are independent.
  - EMPTY->FULL on accept with sel routing to that port.
  - FULL->EMPTY on outXReady with no new accept.
  - FULL->FULL (data replaced) on outXReady plus a same-cycle accept to that port.
  - FULL hold on !outXReady: word and valid stay stable; outX must not change.
- inReady is combinational:
  - sel=0: inReady = !outAValid | outAReady.
  - sel=1: inReady = !outBValid | outBReady.
  - Depends only on the selected port. A stalled port A does not block beats routed to B, and vice versa.
- Accepted beat appears on the selected port's output exactly one cycle later with valid=1. The unselected port is untouched.
- Throughput:
  - One beat per cycle when the selected consumer holds ready=1.
  - Alternating sel with both consumers ready: both ports are valid on alternate cycles, with no bubbles at the input.
- Simultaneous drain and fill of the same port: the old word is consumed and the new word is loaded in the same edge; valid stays 1.
- inValid=0: inData and sel are ignored; no state change except drains.
- A delivered beat is counted on the edge where outXValid & outXReady.
- No ordering is guaranteed between ports; ordering within a port is preserved.

Optional Feature:
- Macro DEMUX_BEAT_CNT_EN.
- Defined: cntA/cntB increment by 1 on each delivered beat of their port.
  - Modulo 2^CNT_W: 0xFFFF+1 wraps to 0x0000.
  - Cleared by reset.
- Undefined: cntA/cntB are tied to 0 and no counter flops are synthesised. Port list is unchanged.

Test Plan:
- Reset: hold Rst=0 for 3 cycles with inValid=1 -> inReady=0, both valids 0, outA=outB=0; after Rst=1, the first beat appears one cycle after acceptance.
- Route: inData=0xDEADBEEF, sel=0, then 0x12345678, sel=1, both readys=1 -> outA=0xDEADBEEF valid in cycle+1, outB=0x12345678 valid in cycle+2, opposite port valid=0 each time.
- Stall isolation: outAReady=0 with A FULL (0xAAAA0001); send sel=0 beat 0xAAAA0002 -> inReady=0, outA holds 0xAAAA0001; send sel=1 beat 0x0000BBBB -> accepted, outB=0x0000BBBB next cycle.
- Drain+fill: A FULL 0x1, outAReady=1, same cycle accept 0x2 sel=0 -> next cycle outAValid=1, outA=0x2; no lost or duplicated beat (scoreboard).
- Reset mid-stall: A and B FULL, both readys=0, pulse Rst=0 for one cycle -> both valids 0 next cycle, held words never delivered.
- With DEMUX_BEAT_CNT_EN: preload by delivering 65535 beats on A then 1 more -> cntA=0x0000, cntB unchanged. Without the macro, cntA=cntB=0 throughout.
